// File: rtl/router_pkg.sv
// Shared definitions for the router output FIFO slice.
//   DEF_DEPTH / DEF_WIDTH / DEF_ADDR_W : default FIFO geometry
//   HDR_FLAG_BIT                       : bit position of the header flag in a stored entry
//   LEN_MSB / LEN_LSB                  : payload-length field inside a header byte
//   REM_W                              : width of the read-side remaining-bytes counter
//   entry_t                            : one stored FIFO entry {hdr_flag, byte}
package router_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_ADDR_W   = 4;
    localparam int HDR_FLAG_BIT = DEF_WIDTH;
    localparam int LEN_MSB      = 7;
    localparam int LEN_LSB      = 2;
    // 6-bit length plus the parity byte can reach 64, so one extra bit is needed.
    localparam int REM_W        = LEN_MSB - LEN_LSB + 2;

    typedef struct packed {
        logic                 hdr_flag;
        logic [DEF_WIDTH-1:0] data;
    } entry_t;

endpackage

// File: rtl/router_fifo_ram.sv
// Storage array for the router output FIFO.
//   clock    : rising-edge clock
//   reset    : synchronous active-high, clears the read register
//   clear    : synchronous flush, forces the read register to zero
//   wr_en    : write wr_data into wr_addr this edge
//   wr_addr  : write address
//   wr_data  : entry {hdr_flag, byte}
//   rd_en    : load the read register from rd_addr this edge
//   rd_addr  : read address
//   rd_data  : registered read data; holds when rd_en is low
module router_fifo_ram
    import router_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH:0]    wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH:0]    rd_data
);

    logic [WIDTH:0] mem_q [DEPTH];
    logic [WIDTH:0] rd_data_q;
    logic [WIDTH:0] rd_data_d;

    // The array itself is never reset; occupancy is tracked by the owner.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (clear) begin
            rd_data_d = '0;
        end else if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/router_output_fifo.sv
// Per-destination output buffer of the 1x3 router.
// Stores header/payload/parity bytes tagged with a header flag, and tracks
// packet length on the read side so the last (parity) byte is flagged.
//   clock, reset          : rising-edge clock, synchronous active-high full clear
//   soft_reset            : synchronous flush of contents; overflow is kept
//   write_enb, lfd_state  : push data_in; lfd_state marks it as a header byte
//   data_in               : byte from the register stage
//   read_enb              : pop one entry
//   data_out, valid_out   : popped byte, valid one cycle after the accepted pop
//   pkt_done              : asserted with the last byte of a packet on data_out
//   full, empty, count    : occupancy status
//   overflow              : sticky, write attempted while full; cleared by reset only
//
// Handshake: a write is accepted when write_enb is high and the FIFO is not
// full, or a read is accepted in the same cycle; a read is accepted when
// read_enb is high and the FIFO is not empty. There is no bypass, so a write
// into an empty FIFO cannot be read in the same cycle. valid_out is a
// one-cycle pulse per accepted read with no back-pressure on the output.
module router_output_fifo
    import router_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              read_enb,
    output logic [WIDTH-1:0]  data_out,
    output logic              valid_out,
    output logic              pkt_done,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [REM_W-1:0]  remaining_q, remaining_d;
    logic              valid_out_q, valid_out_d;
    logic              overflow_q, overflow_d;

    logic              wr_acc;
    logic              rd_acc;
    logic [WIDTH:0]    rd_data;

    assign full   = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = read_enb && !empty;
    assign wr_acc = write_enb && (!full || rd_acc);

    router_fifo_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .clear   (soft_reset),
        .wr_en   (wr_acc && !soft_reset),
        .wr_addr (wr_ptr_q),
        .wr_data ({lfd_state, data_in}),
        .rd_en   (rd_acc && !soft_reset),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        valid_out_d = 1'b0;
        overflow_d  = overflow_q;

        // The length tracker consumes the entry currently presented on the
        // read register, so its update lines up with the byte's valid_out.
        if (valid_out_q) begin
            if (rd_data[WIDTH]) begin
                remaining_d = REM_W'(rd_data[LEN_MSB:LEN_LSB]) + REM_W'(1);
            end else if (remaining_q != '0) begin
                remaining_d = remaining_q - REM_W'(1);
            end
        end

        if (soft_reset) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            remaining_d = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            valid_out_d = rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (write_enb && !wr_acc) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            remaining_q <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            valid_out_q <= valid_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign data_out  = rd_data[WIDTH-1:0];
    assign valid_out = valid_out_q;
    assign pkt_done  = valid_out_q && !rd_data[WIDTH] && (remaining_q == REM_W'(1));
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
